sync_word_framer_5: RTL

// - Downstream consumer of the 5-bit serial-in/parallel-out shift stage; receives that stage's

---
 rtl/sync_word_framer_5.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sync_word_framer_5.sv
// Sync-word framer: hunts for SYNC_WORD in the shift-stage window, then frames 5-bit words.
// Optional sync-slot error counter enabled by defining SYNC_ERR_CNT_EN.
module sync_word_framer_5 #(
  parameter logic [4:0]  SYNC_WORD = 5'b10110,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned MISS_MAX  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [4:0] din,
  input  logic       clear,
  output logic [4:0] word,
  output logic       word_valid,
  output logic       locked
`ifdef SYNC_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int unsigned     SlotW    = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [SlotW-1:0] SlotLast = SlotW'(FRAME_LEN - 1);
  localparam logic [2:0]       MissMax  = 3'(MISS_MAX);

  typedef enum logic {StHunt, StLocked} state_e;

  state_e           state_q, state_d;
  logic             en_q;
  logic [2:0]       bit_q, bit_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [2:0]       miss_q, miss_d;
  logic [4:0]       word_q, word_d;
  logic             valid_q, valid_d;

  logic sync_hit, boundary, sync_miss;

  // en_q marks the cycle where din already holds the freshly shifted window
  assign sync_hit  = (din == SYNC_WORD);
  assign boundary  = en_q && !clear && (state_q == StLocked) && (bit_q == 3'd4);
  assign sync_miss = boundary && (slot_q == '0) && !sync_hit;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    slot_d  = slot_q;
    miss_d  = miss_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear) begin
      state_d = StHunt;
      bit_d   = '0;
      slot_d  = '0;
      miss_d  = '0;
    end else if (en_q) begin
      unique case (state_q)
        StHunt: begin
          if (sync_hit) begin
            state_d = StLocked;
            bit_d   = '0;
            slot_d  = SlotW'(1);
            miss_d  = '0;
          end
        end
        StLocked: begin
          if (!boundary) begin
            bit_d = bit_q + 3'd1;
          end else begin
            bit_d  = '0;
            slot_d = (slot_q == SlotLast) ? '0 : slot_q + SlotW'(1);
            if (slot_q != '0) begin
              word_d  = din;
              valid_d = 1'b1;
            end else if (sync_hit) begin
              miss_d = '0;
            end else if (miss_q + 3'd1 == MissMax) begin
              // Lock lost; this window is not reconsidered as a sync candidate
              state_d = StHunt;
              bit_d   = '0;
              slot_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 3'd1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StHunt;
      en_q    <= 1'b0;
      bit_q   <= '0;
      slot_q  <= '0;
      miss_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en;
      bit_q   <= bit_d;
      slot_q  <= slot_d;
      miss_q  <= miss_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;
  assign locked     = (state_q == StLocked);

`ifdef SYNC_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= '0;
    end else if (clear) begin
      err_q <= '0;
    end else if (sync_miss && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;
`endif

endmodule
